// File: rtl/pixel_serializer.sv
// pixel_serializer: buffers RGB pixels in a FIFO and emits each one as R, G, B words with a valid/ready handshake.
// Optional macro PIXEL_SERIALIZER_COUNT_EN adds a 32-bit pixel_count output.
module pixel_serializer #(
    parameter int PIXEL_WIDTH = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_valid,
    input  logic [PIXEL_WIDTH-1:0]        pixel_in_red,
    input  logic [PIXEL_WIDTH-1:0]        pixel_in_green,
    input  logic [PIXEL_WIDTH-1:0]        pixel_in_blue,
    output logic [PIXEL_WIDTH-1:0]        out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PIXEL_SERIALIZER_COUNT_EN
    ,
    output logic [31:0]                   pixel_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND_R, SEND_G, SEND_B} state_e;

    state_e                 state_q, state_d;
    logic [PIXEL_WIDTH-1:0] red_q   [FIFO_DEPTH];
    logic [PIXEL_WIDTH-1:0] green_q [FIFO_DEPTH];
    logic [PIXEL_WIDTH-1:0] blue_q  [FIFO_DEPTH];
    logic [AW-1:0]          wr_q, rd_q;
    logic [AW:0]            level_q, level_d;
    logic                   overflow_q, full, push, pop;

    // Fullness is judged before any same-cycle pop, so a full FIFO drops even while draining.
    assign full    = level_q == FULL;
    assign push    = data_valid && !full;
    assign pop     = state_q == SEND_B && out_ready;
    assign level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_d   = state_q;
        out_valid = state_q != IDLE;
        out_last  = state_q == SEND_B;
        out_data  = state_q == SEND_R ? red_q[rd_q]   :
                    state_q == SEND_G ? green_q[rd_q] :
                    state_q == SEND_B ? blue_q[rd_q]  : '0;
        case (state_q)
            IDLE:    state_d = level_q != '0 ? SEND_R : IDLE;
            SEND_R:  state_d = out_ready ? SEND_G : SEND_R;
            SEND_G:  state_d = out_ready ? SEND_B : SEND_G;
            SEND_B:  state_d = !out_ready ? SEND_B : (level_d != '0 ? SEND_R : IDLE);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            if (data_valid && full) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible while level_q counts them.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            red_q[wr_q]   <= pixel_in_red;
            green_q[wr_q] <= pixel_in_green;
            blue_q[wr_q]  <= pixel_in_blue;
        end
    end

    assign overflow   = overflow_q;
    assign fifo_level = level_q;

`ifdef PIXEL_SERIALIZER_COUNT_EN
    logic [31:0] pixel_count_q;

    always_ff @(posedge clk) begin
        if (reset) pixel_count_q <= '0;
        else if (pop) pixel_count_q <= pixel_count_q + 32'd1;
    end

    assign pixel_count = pixel_count_q;
`endif
endmodule

// File: tb/tb_pixel_serializer.sv
// tb_pixel_serializer: directed scenarios plus randomized traffic, checked every cycle against a queue-based pixel model.
module tb_pixel_serializer;
    localparam int PW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset, data_valid, out_ready;
    logic [PW-1:0] pixel_in_red, pixel_in_green, pixel_in_blue;
    logic [PW-1:0] out_data;
    logic          out_valid, out_last, overflow;
    logic [2:0]    fifo_level;
`ifdef PIXEL_SERIALIZER_COUNT_EN
    logic [31:0]   pixel_count;
`endif

    pixel_serializer #(.PIXEL_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .data_valid(data_valid),
        .pixel_in_red(pixel_in_red), .pixel_in_green(pixel_in_green), .pixel_in_blue(pixel_in_blue),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .overflow(overflow), .fifo_level(fifo_level)
`ifdef PIXEL_SERIALIZER_COUNT_EN
        , .pixel_count(pixel_count)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: pending pixels as {r,g,b}; the head pixel is being sent while m_active, word m_widx next.
    logic [3*PW-1:0] mq[$];
    bit              m_active;
    int              m_widx;
    bit              m_ovf;
    logic [31:0]     m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] chan(input logic [3*PW-1:0] p, input int w);
        return w == 0 ? p[3*PW-1:2*PW] : w == 1 ? p[2*PW-1:PW] : p[PW-1:0];
    endfunction

    function automatic logic [3*PW-1:0] pix(input int i);
        return {PW'(16'h1000 + i), PW'(16'h2000 + i), PW'(16'h3000 + i)};
    endfunction

    task automatic model_step();
        bit full, hs, start, popped;
        if (reset) begin
            mq.delete();
            m_active = 0;
            m_widx = 0;
            m_ovf = 0;
            m_cnt = '0;
            return;
        end
        full = mq.size() == DEPTH;
        hs = m_active && out_ready;
        start = !m_active && mq.size() > 0;
        popped = 0;
        if (data_valid && full) m_ovf = 1;
        if (hs) begin
            if (m_widx == 2) begin
                void'(mq.pop_front());
                m_widx = 0;
                m_cnt = m_cnt + 32'd1;
                popped = 1;
            end else m_widx++;
        end
        if (data_valid && !full) mq.push_back({pixel_in_red, pixel_in_green, pixel_in_blue});
        if (start) m_active = 1;
        else if (popped) m_active = mq.size() > 0;
    endtask

    task automatic cyc(input logic dv, input logic [3*PW-1:0] p, input logic rdy, input logic rst);
        data_valid = dv;
        {pixel_in_red, pixel_in_green, pixel_in_blue} = p;
        out_ready = rdy;
        reset = rst;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("valid", out_valid, m_active);
                check("data", out_data, m_active ? chan(mq[0], m_widx) : '0);
                check("last", out_last, m_active && m_widx == 2);
                check("overflow", overflow, m_ovf);
                check("level", fifo_level, mq.size());
`ifdef PIXEL_SERIALIZER_COUNT_EN
                check("pixel_count", pixel_count, m_cnt);
`endif
            end
        end
    end

    initial begin
        int n, first, lastv, vcount;
        logic [PW-1:0] lastw;
        logic [9:0] lastmask;
        cyc(0, '0, 0, 1);
        cyc(0, '0, 0, 1);
        chk_en = 1'b1;
        check("rst_valid", out_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_data", out_data, 0);

        // single pixel, full-rate readout
        cyc(1, 48'h1234_5678_9ABC, 1, 0);
        check("one_wait", out_valid, 0);
        cyc(0, '0, 1, 0);
        check("one_r", {out_valid, out_last, out_data}, {2'b10, 16'h1234});
        cyc(0, '0, 1, 0);
        check("one_g", {out_valid, out_last, out_data}, {2'b10, 16'h5678});
        cyc(0, '0, 1, 0);
        check("one_b", {out_valid, out_last, out_data}, {2'b11, 16'h9ABC});
        cyc(0, '0, 1, 0);
        check("one_idle", out_valid, 0);

        // stall in the green word
        cyc(1, 48'hAAAA_BBBB_CCCC, 1, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        check("stall_g0", out_data, 16'hBBBB);
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, 0, 0);
            check("stall_hold", {out_valid, out_last, out_data}, {2'b10, 16'hBBBB});
        end
        cyc(0, '0, 1, 0);
        check("stall_b", {out_valid, out_last, out_data}, {2'b11, 16'hCCCC});
        cyc(0, '0, 1, 0);

        // overflow: five pixels into a stalled four-deep FIFO
        for (int i = 0; i < 5; i++) cyc(1, pix(i), 0, 0);
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", out_data, 16'h1000);
        n = 0;
        lastw = '0;
        for (int i = 0; i < 13; i++) begin
            if (out_valid) begin
                n++;
                lastw = out_data;
            end
            cyc(0, '0, 1, 0);
        end
        check("ovf_words", n, 12);
        check("ovf_lastword", lastw, 16'h3003);
        check("ovf_sticky", overflow, 1);

        // back-to-back pixels
        vcount = 0;
        first = -1;
        lastv = -1;
        lastmask = '0;
        for (int i = 0; i < 14; i++) begin
            cyc(i < 3, pix(8 + i), 1, 0);
            if (out_valid) begin
                vcount++;
                if (first < 0) first = i;
                lastv = i;
                if (out_last) lastmask[vcount] = 1'b1;
            end
        end
        check("b2b_words", vcount, 9);
        check("b2b_span", lastv - first + 1, 9);
        check("b2b_lasts", lastmask, 10'h248);

        // reset mid-pixel with two buffered
        cyc(1, pix(20), 1, 0);
        cyc(1, pix(21), 1, 0);
        cyc(0, '0, 1, 0);
        check("mid_g", out_data, 16'h2014);
        check("mid_level", fifo_level, 2);
        cyc(0, '0, 1, 1);
        check("mid_rst", {out_valid, out_last, overflow, fifo_level, out_data}, '0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, '0, 1, 0);
            check("mid_stale", out_valid, 0);
        end
`ifdef PIXEL_SERIALIZER_COUNT_EN
        for (int i = 0; i < 3; i++) cyc(1, pix(i), 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, '0, 1, 0);
        check("count3", pixel_count, 3);
        cyc(0, '0, 1, 1);
        check("count_rst", pixel_count, 0);
`endif

        // randomized traffic, alternating ready-heavy and ready-starved phases
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 400; i++) begin
                cyc($urandom_range(0, 99) < 40,
                    {PW'($urandom), PW'($urandom), PW'($urandom)},
                    $urandom_range(0, 99) < ((k % 2) ? 90 : 25),
                    $urandom_range(0, 299) == 0);
            end
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
